// File: rtl/conv_pkg.sv
// Shared definitions for the convolution valid-window generator.
//   state_t      : frame FSM states (IDLE, RUN, DONE)
//   DEF_*        : default image geometry, kernel size and stride
//   num_windows  : number of valid output windows in one frame
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_IMG_W  = 32;
    localparam int DEF_IMG_H  = 32;
    localparam int DEF_KERNEL = 5;
    localparam int DEF_STRIDE = 1;

    function automatic int num_windows(input int w, input int h, input int k, input int s);
        return ((w - k) / s + 1) * ((h - k) / s + 1);
    endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Wrapping position counter for one image axis, with a stride phase
// counter and an output-map index so no division is ever needed.
// All outputs describe the position of the pixel accepted this cycle
// (i.e. after an optional clear has been applied).
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the axis at position 0 this cycle
//   adv        : a pixel is consumed at the current position; step on
//   last       : current position is N-1
//   ready      : current position ends a kernel window on a stride step
//   idx        : output-map index of that window, (pos-KERNEL+1)/STRIDE
module conv_pos_counter
    import conv_pkg::*;
#(
    parameter int N      = DEF_IMG_W,
    parameter int KERNEL = DEF_KERNEL,
    parameter int STRIDE = DEF_STRIDE,
    localparam int W     = (N > 1) ? $clog2(N) : 1
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         adv,
    output logic         last,
    output logic         ready,
    output logic [W-1:0] idx
);

    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    logic [W-1:0]  pos_q, pos_base, pos_d;
    logic [PW-1:0] phase_q, phase_base, phase_d;
    logic [W-1:0]  idx_q, idx_base, idx_d;

    always_comb begin
        pos_base   = clear ? '0 : pos_q;
        phase_base = clear ? '0 : phase_q;
        idx_base   = clear ? '0 : idx_q;

        last  = (pos_base == W'(N - 1));
        // phase only starts moving once the first window edge is reached,
        // so phase==0 there marks every STRIDE-th position from KERNEL-1
        ready = (int'(pos_base) >= KERNEL - 1) && (phase_base == '0);
        idx   = idx_base;

        pos_d   = pos_base;
        phase_d = phase_base;
        idx_d   = idx_base;
        if (adv) begin
            if (last) begin
                pos_d   = '0;
                phase_d = '0;
                idx_d   = '0;
            end else begin
                pos_d = pos_base + W'(1);
                if (int'(pos_base) >= KERNEL - 1) begin
                    if (phase_base == PW'(STRIDE - 1)) begin
                        phase_d = '0;
                        idx_d   = idx_base + W'(1);
                    end else begin
                        phase_d = phase_base + PW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q   <= '0;
            phase_q <= '0;
            idx_q   <= '0;
        end else begin
            pos_q   <= pos_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/conv_valid_gen.sv
// Convolution valid-window generator. Tracks the raster position of an
// incoming pixel stream and pulses out_valid one cycle after each pixel
// that completes a KERNEL x KERNEL window on the STRIDE grid.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : frame-start pulse; a pixel in this cycle is (0,0)
//   in_valid    : one pixel accepted this cycle (raster order)
//   out_valid   : registered window-complete pulse
//   out_row/col : output-map coordinates, held while out_valid is low
//   busy        : frame in progress
//   frame_done  : single-cycle pulse after the last pixel of a frame
//   win_count   : windows emitted in the current frame
//                 (present only when CONV_VALID_CNT_EN is defined)
module conv_valid_gen
    import conv_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int KERNEL = DEF_KERNEL,
    parameter int STRIDE = DEF_STRIDE,
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             out_valid,
    output logic [ROW_W-1:0] out_row,
    output logic [COL_W-1:0] out_col,
    output logic             busy,
`ifdef CONV_VALID_CNT_EN
    output logic [$clog2(num_windows(IMG_W, IMG_H, KERNEL, STRIDE)):0] win_count,
`endif
    output logic             frame_done
);

    if (KERNEL < 1 || STRIDE < 1 || KERNEL > IMG_W || KERNEL > IMG_H) begin : g_param_check
        $error("conv_valid_gen: illegal KERNEL/STRIDE for the image size");
    end

    state_t state_q, state_d;

    logic             accept;
    logic             col_last, col_ready;
    logic             row_last, row_ready;
    logic [COL_W-1:0] col_idx;
    logic [ROW_W-1:0] row_idx;
    logic             win_hit;

    // start both accepts a pixel and restarts the counters, so a pixel
    // arriving with start is evaluated at (0,0)
    assign accept  = in_valid && (start || state_q == RUN);
    assign win_hit = accept && col_ready && row_ready;

    conv_pos_counter #(.N(IMG_W), .KERNEL(KERNEL), .STRIDE(STRIDE)) u_col (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start),
        .adv   (accept),
        .last  (col_last),
        .ready (col_ready),
        .idx   (col_idx)
    );

    conv_pos_counter #(.N(IMG_H), .KERNEL(KERNEL), .STRIDE(STRIDE)) u_row (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start),
        .adv   (accept && col_last),
        .last  (row_last),
        .ready (row_ready),
        .idx   (row_idx)
    );

    always_comb begin
        state_d    = IDLE;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            RUN:     busy       = 1'b1;
            DONE:    frame_done = 1'b1;
            default: ;
        endcase
        if (accept && col_last && row_last) begin
            state_d = DONE;
        end else if (start || state_q == RUN) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            state_q   <= state_d;
            out_valid <= win_hit;
            if (win_hit) begin
                out_row <= row_idx;
                out_col <= col_idx;
            end
        end
    end

`ifdef CONV_VALID_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_count <= '0;
        end else if (start) begin
            win_count <= win_hit ? 1 : 0;
        end else if (win_hit) begin
            win_count <= win_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_valid_gen.sv
// Self-checking bench for conv_valid_gen: a 32x32/K5/S1 instance driven
// against a pixel-index reference model, and an 8x8/K3/S2 instance
// checked against a hand-written pulse table.
module tb_conv_valid_gen;

    localparam int IW = 32, IH = 32, K = 5, S = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic       start_a = 1'b0, in_valid_a = 1'b0;
    logic       out_valid_a, busy_a, frame_done_a;
    logic [4:0] out_row_a, out_col_a;

    logic       start_b = 1'b0, in_valid_b = 1'b0;
    logic       out_valid_b, busy_b, frame_done_b;
    logic [2:0] out_row_b, out_col_b;

`ifdef CONV_VALID_CNT_EN
    logic [10:0] win_count_a;
    logic [4:0]  win_count_b;
`endif

    conv_valid_gen dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_a),
        .in_valid   (in_valid_a),
        .out_valid  (out_valid_a),
        .out_row    (out_row_a),
        .out_col    (out_col_a),
        .busy       (busy_a),
`ifdef CONV_VALID_CNT_EN
        .win_count  (win_count_a),
`endif
        .frame_done (frame_done_a)
    );

    conv_valid_gen #(.IMG_W(8), .IMG_H(8), .KERNEL(3), .STRIDE(2)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .in_valid   (in_valid_b),
        .out_valid  (out_valid_b),
        .out_row    (out_row_b),
        .out_col    (out_col_b),
        .busy       (busy_b),
`ifdef CONV_VALID_CNT_EN
        .win_count  (win_count_b),
`endif
        .frame_done (frame_done_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model of dut_a, expressed with pixel index arithmetic
    int   m_state = 0;   // 0 idle, 1 run, 2 done
    int   m_k     = 0;
    logic exp_valid = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
    int   exp_row = 0, exp_col = 0;

    // Drive one cycle on dut_a (called at a falling edge); on return the
    // next falling edge has been reached and exp_* describe the outputs.
    task automatic tick(input logic s, input logic v);
        logic acc;
        int   r, c;
        start_a    = s;
        in_valid_a = v;
        acc        = v && (s || m_state == 1);
        exp_valid  = 1'b0;
        if (s) m_k = 0;
        if (acc) begin
            r = m_k / IW;
            c = m_k % IW;
            if (r >= K-1 && c >= K-1 && (r-K+1) % S == 0 && (c-K+1) % S == 0) begin
                exp_valid = 1'b1;
                exp_row   = (r-K+1) / S;
                exp_col   = (c-K+1) / S;
            end
            if (m_k == IW*IH-1) begin
                m_state = 2;
                m_k     = 0;
            end else begin
                m_state = 1;
                m_k++;
            end
        end else if (s) begin
            m_state = 1;
        end else if (m_state == 2) begin
            m_state = 0;
        end
        exp_busy = (m_state == 1);
        exp_done = (m_state == 2);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({out_valid_a, busy_a, frame_done_a, out_row_a, out_col_a} !== 13'd0)
            $display("FAIL reset_a: outputs got %b want 0",
                     {out_valid_a, busy_a, frame_done_a, out_row_a, out_col_a});
        else n_pass++;
        n_checks++;
        if ({out_valid_b, busy_b, frame_done_b, out_row_b, out_col_b} !== 9'd0)
            $display("FAIL reset_b: outputs got %b want 0",
                     {out_valid_b, busy_b, frame_done_b, out_row_b, out_col_b});
        else n_pass++;
`ifdef CONV_VALID_CNT_EN
        n_checks++;
        if (win_count_a !== 11'd0) $display("FAIL reset_cnt: win_count got %0d want 0", win_count_a);
        else n_pass++;
`endif
        rst_n = 1'b1;
        // pixels offered in IDLE without start are ignored
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1);
            n_checks++;
            if ({out_valid_a, busy_a, frame_done_a} !== 3'b000)
                $display("FAIL idle_ignore cyc %0d: valid/busy/done got %b want 000",
                         i, {out_valid_a, busy_a, frame_done_a});
            else n_pass++;
        end
    endtask

    task automatic test_continuous();
        int pulses = 0, dones = 0, first_pix = -1;
        for (int i = 0; i < IW*IH + 3; i++) begin
            tick(i == 0, i < IW*IH);
            n_checks++;
            if ({out_valid_a, busy_a, frame_done_a} !== {exp_valid, exp_busy, exp_done})
                $display("FAIL cont_ctrl pix %0d: valid/busy/done got %b want %b",
                         i, {out_valid_a, busy_a, frame_done_a}, {exp_valid, exp_busy, exp_done});
            else n_pass++;
            if (exp_valid) begin
                n_checks++;
                if ({out_row_a, out_col_a} !== {5'(exp_row), 5'(exp_col)})
                    $display("FAIL cont_coord pix %0d: row/col got %0d/%0d want %0d/%0d",
                             i, out_row_a, out_col_a, exp_row, exp_col);
                else n_pass++;
            end
`ifdef CONV_VALID_CNT_EN
            if (frame_done_a) begin
                n_checks++;
                if (win_count_a !== 11'd784) $display("FAIL cont_cnt: win_count got %0d want 784", win_count_a);
                else n_pass++;
            end
`endif
            if (out_valid_a) begin
                if (first_pix < 0) first_pix = i;
                pulses++;
            end
            if (frame_done_a) dones++;
        end
        n_checks++;
        if (first_pix !== 132) $display("FAIL cont_first: first pulse pixel got %0d want 132", first_pix);
        else n_pass++;
        n_checks++;
        if (pulses !== 784) $display("FAIL cont_pulses: got %0d want 784", pulses);
        else n_pass++;
        n_checks++;
        if (dones !== 1) $display("FAIL cont_done: frame_done count got %0d want 1", dones);
        else n_pass++;
        n_checks++;
        if ({out_row_a, out_col_a} !== {5'd27, 5'd27})
            $display("FAIL cont_hold: row/col got %0d/%0d want 27/27", out_row_a, out_col_a);
        else n_pass++;
    endtask

    task automatic test_random_stall();
        int   accepted = 0, cyc = 0, post = 0, pulses = 0, dones = 0;
        logic v;
        while (post < 3 && cyc < 8000) begin
            if (cyc == 0) v = 1'b1;
            else if (accepted < IW*IH) v = 1'($urandom_range(0, 1));
            else begin v = 1'b0; post++; end
            tick(cyc == 0, v);
            if (v) accepted++;
            n_checks++;
            if ({out_valid_a, busy_a, frame_done_a} !== {exp_valid, exp_busy, exp_done})
                $display("FAIL rand_ctrl cyc %0d: valid/busy/done got %b want %b",
                         cyc, {out_valid_a, busy_a, frame_done_a}, {exp_valid, exp_busy, exp_done});
            else n_pass++;
            if (exp_valid) begin
                n_checks++;
                if ({out_row_a, out_col_a} !== {5'(exp_row), 5'(exp_col)})
                    $display("FAIL rand_coord cyc %0d: row/col got %0d/%0d want %0d/%0d",
                             cyc, out_row_a, out_col_a, exp_row, exp_col);
                else n_pass++;
            end
`ifdef CONV_VALID_CNT_EN
            if (cyc == 0) begin
                n_checks++;
                if (win_count_a !== 11'd0) $display("FAIL rand_cnt_clear: win_count got %0d want 0", win_count_a);
                else n_pass++;
            end
`endif
            if (out_valid_a) pulses++;
            if (frame_done_a) dones++;
            cyc++;
        end
        n_checks++;
        if (accepted !== IW*IH) $display("FAIL rand_budget: accepted %0d pixels want 1024", accepted);
        else n_pass++;
        n_checks++;
        if (pulses !== 784) $display("FAIL rand_pulses: got %0d want 784", pulses);
        else n_pass++;
        n_checks++;
        if (dones !== 1) $display("FAIL rand_done: frame_done count got %0d want 1", dones);
        else n_pass++;
    endtask

    task automatic test_restart();
        int pulses_new = 0, dones = 0;
        for (int i = 0; i < 500 + IW*IH + 3; i++) begin
            tick(i == 0 || i == 500, i < 500 + IW*IH);
            n_checks++;
            if ({out_valid_a, busy_a, frame_done_a} !== {exp_valid, exp_busy, exp_done})
                $display("FAIL restart_ctrl cyc %0d: valid/busy/done got %b want %b",
                         i, {out_valid_a, busy_a, frame_done_a}, {exp_valid, exp_busy, exp_done});
            else n_pass++;
            if (exp_valid) begin
                n_checks++;
                if ({out_row_a, out_col_a} !== {5'(exp_row), 5'(exp_col)})
                    $display("FAIL restart_coord cyc %0d: row/col got %0d/%0d want %0d/%0d",
                             i, out_row_a, out_col_a, exp_row, exp_col);
                else n_pass++;
            end
`ifdef CONV_VALID_CNT_EN
            if (i == 500) begin
                n_checks++;
                if (win_count_a !== 11'd0) $display("FAIL restart_cnt: win_count got %0d want 0", win_count_a);
                else n_pass++;
            end
`endif
            if (out_valid_a && i >= 500) pulses_new++;
            if (frame_done_a) dones++;
        end
        n_checks++;
        if (pulses_new !== 784) $display("FAIL restart_pulses: got %0d want 784", pulses_new);
        else n_pass++;
        n_checks++;
        if (dones !== 1) $display("FAIL restart_done: frame_done count got %0d want 1", dones);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 300; i++) tick(i == 0, 1'b1);
        // pixel 299 is (9,11): window (5,7) just emitted
        n_checks++;
        if ({out_valid_a, out_row_a, out_col_a} !== {1'b1, 5'd5, 5'd7})
            $display("FAIL mid_pre: valid/row/col got %b/%0d/%0d want 1/5/7",
                     out_valid_a, out_row_a, out_col_a);
        else n_pass++;
        in_valid_a = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid_a, busy_a, frame_done_a, out_row_a, out_col_a} !== 13'd0)
            $display("FAIL mid_async: outputs got %b want 0",
                     {out_valid_a, busy_a, frame_done_a, out_row_a, out_col_a});
        else n_pass++;
        m_state = 0; m_k = 0;
        exp_valid = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_row = 0; exp_col = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, 1'b1);
            n_checks++;
            if ({out_valid_a, busy_a, frame_done_a, out_row_a, out_col_a} !== 13'd0)
                $display("FAIL mid_after cyc %0d: outputs got %b want 0",
                         i, {out_valid_a, busy_a, frame_done_a, out_row_a, out_col_a});
            else n_pass++;
        end
        tick(1'b0, 1'b0);
    endtask

    task automatic test_small_stride();
        int exp_pix [9] = '{18, 20, 22, 34, 36, 38, 50, 52, 54};
        int rec_pix [16];
        int rec_rc  [16];
        int n = 0, dones = 0;
        for (int i = 0; i < 67; i++) begin
            start_b    = (i == 0);
            in_valid_b = (i < 64);
            @(negedge clk);
            if (out_valid_b) begin
                if (n < 16) begin
                    rec_pix[n] = i;
                    rec_rc[n]  = {26'd0, out_row_b, out_col_b};
                end
                n++;
            end
            if (frame_done_b) dones++;
        end
        start_b = 1'b0; in_valid_b = 1'b0;
        n_checks++;
        if (n !== 9) $display("FAIL small_pulses: got %0d want 9", n);
        else n_pass++;
        for (int j = 0; j < 9 && j < n; j++) begin
            n_checks++;
            if (rec_pix[j] !== exp_pix[j] || rec_rc[j] !== (j / 3) * 8 + (j % 3))
                $display("FAIL small_win %0d: pixel %0d rowcol %0d want pixel %0d rowcol %0d",
                         j, rec_pix[j], rec_rc[j], exp_pix[j], (j / 3) * 8 + (j % 3));
            else n_pass++;
        end
        n_checks++;
        if (dones !== 1) $display("FAIL small_done: frame_done count got %0d want 1", dones);
        else n_pass++;
`ifdef CONV_VALID_CNT_EN
        n_checks++;
        if (win_count_b !== 5'd9) $display("FAIL small_cnt: win_count got %0d want 9", win_count_b);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_random_stall();
        test_restart();
        test_reset_mid();
        test_small_stride();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/conv_valid_gen.md
CONV_VALID_GEN -- requirements
Module: conv_valid_gen

Interface
REQ-001 Parameter IMG_W, default 32, input image width in pixels.
REQ-002 Parameter IMG_H, default 32, input image height in pixels.
REQ-003 Parameter KERNEL, default 5, square convolution kernel size.
REQ-004 Parameter STRIDE, default 1, window step in both dimensions.
REQ-005 Port clk  input  1  single clock, rising edge.
REQ-006 Port rst_n  input  1  asynchronous active-low reset.
REQ-007 Port start  input  1  frame-start pulse.
REQ-008 Port in_valid  input  1  one pixel accepted this cycle (raster order).
REQ-009 Port out_valid  output  1  conv window complete; registered.
REQ-010 Port out_row  output  $clog2(IMG_H)  output-map row of current out_valid.
REQ-011 Port out_col  output  $clog2(IMG_W)  output-map column of current out_valid.
REQ-012 Port busy  output  1  frame in progress (state RUN).
REQ-013 Port frame_done  output  1  one-cycle pulse after last pixel of frame.

Function
REQ-014 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on in_valid of pixel (IMG_H-1, IMG_W-1); DONE->IDLE next cycle, or DONE->RUN if start.
REQ-015 Pixel counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on in_valid in RUN; col wraps to 0 and increments row; row wraps to 0 at frame end.
REQ-016 in_valid in the start cycle counts as pixel (0,0); in_valid in IDLE or DONE without start is ignored.
REQ-017 Window-complete condition: row>=KERNEL-1, col>=KERNEL-1, (row-KERNEL+1) mod STRIDE==0, (col-KERNEL+1) mod STRIDE==0; modulo implemented with stride phase counters, no dividers.
REQ-018 out_valid asserts exactly 1 cycle after the in_valid cycle satisfying REQ-017, for one cycle; deasserted otherwise, including stall cycles.
REQ-019 out_row/out_col give (row-KERNEL+1)/STRIDE and (col-KERNEL+1)/STRIDE, registered with out_valid; hold last value when out_valid low.
REQ-020 Valid windows per frame = ((IMG_W-KERNEL)/STRIDE+1)*((IMG_H-KERNEL)/STRIDE+1).
REQ-021 start in RUN restarts the frame: counters cleared, the start-cycle pixel is (0,0), no frame_done for the aborted frame.
REQ-022 frame_done asserted for the single DONE cycle, coincident with the last possible out_valid.
REQ-023 Elaboration error if KERNEL>IMG_W, KERNEL>IMG_H, KERNEL<1 or STRIDE<1.

Reset
REQ-024 rst_n low asynchronously forces IDLE, counters 0, out_valid 0, out_row 0, out_col 0, busy 0, frame_done 0.
REQ-025 Reset mid-frame aborts the frame; no outputs pulse after release until a new start.

Configuration
REQ-026 Macro CONV_VALID_CNT_EN defined: extra output win_count (width $clog2 of REQ-020 value +1) counts out_valid pulses in current frame, cleared on start and reset, held through DONE/IDLE.
REQ-027 Macro CONV_VALID_CNT_EN undefined: win_count port and counter absent; all other behaviour identical.

Structure
REQ-028 Package conv_pkg holds the FSM state typedef (IDLE, RUN, DONE) and default IMG_W/IMG_H/KERNEL/STRIDE constants.
REQ-029 Sub-module conv_pos_counter (wrapping position counter with stride phase and window-ready flag) instantiated once for columns, once for rows.

Verification
REQ-030 Defaults, start then in_valid held 1024 cycles -> first out_valid 1 cycle after pixel index 132 (row 4, col 4), out_row=0/out_col=0; 784 pulses; 28 valid then 4 idle per row; frame_done once.
REQ-031 IMG_W=IMG_H=8, KERNEL=3, STRIDE=2, continuous -> 9 pulses at pixels (2,2),(2,4),(2,6),(4,2)..(6,6); out_row/out_col 0..2.
REQ-032 Defaults, in_valid random 50% -> same 784 pulses and coordinates as REQ-030; no out_valid on stall-following cycles without a qualifying pixel.
REQ-033 start reasserted at pixel 500 -> counters restart, no frame_done for aborted frame, next frame yields 784 pulses.
REQ-034 rst_n low at pixel 300 -> all outputs 0 immediately; in_valid after release without start -> no out_valid.
REQ-035 CONV_VALID_CNT_EN defined, defaults -> win_count=784 at frame_done; cleared to 0 on next start.
